// File: rtl/cpu_move_sequencer.sv
// Computer-turn move sequencer: arm on request, think, snapshot the board, offer a free cell.
// Optional CPU_CENTER_FIRST_EN macro makes the selector prefer CENTER_IDX when that cell is free.
module cpu_move_sequencer #(
    parameter int CELLS        = 9,
    parameter int IDX_W        = 4,
    parameter int THINK_CYCLES = 3,
    parameter int CNT_W        = 8,
    parameter int CENTER_IDX   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cpu_en,
    input  logic [CELLS-1:0] board_occ,
    input  logic             move_ready,
    output logic             move_valid,
    output logic [IDX_W-1:0] move_idx,
    output logic             busy,
    output logic             no_move,
    output logic [CNT_W-1:0] turn_count
);

    localparam int TW = (THINK_CYCLES < 1) ? 1 : $clog2(THINK_CYCLES + 1);

`ifdef CPU_CENTER_FIRST_EN
    localparam bit CENTER_FIRST = 1'b1;
`else
    localparam bit CENTER_FIRST = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        THINK,
        OFFER,
        FULL
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    cnt_q;
    logic [CELLS-1:0] snap_q;
    logic             move_valid_q;
    logic [IDX_W-1:0] move_idx_q;
    logic             busy_q;
    logic             no_move_q;
    logic [CNT_W-1:0] turn_count_q;
    logic [IDX_W-1:0] pick_d;

    // Lowest free cell of the snapshot, optionally overridden by a free center cell.
    always_comb begin
        // NOTE: default first so every path assigns pick_d and no latch is inferred.
        pick_d = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (!snap_q[i]) pick_d = IDX_W'(i);
        end
        if (CENTER_FIRST && !snap_q[CENTER_IDX]) pick_d = IDX_W'(CENTER_IDX);
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            snap_q       <= '0;
            move_valid_q <= 1'b0;
            move_idx_q   <= '0;
            busy_q       <= 1'b0;
            no_move_q    <= 1'b0;
            turn_count_q <= '0;
        end else begin
            no_move_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && cpu_en) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    if (!cpu_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        snap_q <= board_occ;
                        if (&board_occ) begin
                            state_q <= FULL;
                        end else if (THINK_CYCLES == 0) begin
                            state_q <= OFFER;
                        end else begin
                            state_q <= THINK;
                            cnt_q   <= TW'(THINK_CYCLES);
                        end
                    end
                end
                THINK: begin
                    if (!cpu_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == TW'(1)) state_q <= OFFER;
                    end
                end
                OFFER: begin
                    // An accepted handshake takes priority over a simultaneous disable.
                    if (move_valid_q && move_ready) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        move_valid_q <= 1'b0;
                        turn_count_q <= turn_count_q + 1'b1;
                    end else if (!cpu_en) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        move_valid_q <= 1'b0;
                    end else if (!move_valid_q) begin
                        move_valid_q <= 1'b1;
                        move_idx_q   <= pick_d;
                    end
                end
                FULL: begin
                    no_move_q <= 1'b1;
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign move_valid = move_valid_q;
    assign move_idx   = move_idx_q;
    assign busy       = busy_q;
    assign no_move    = no_move_q;
    assign turn_count = turn_count_q;

endmodule

// File: doc/cpu_move_sequencer.md
Name: cpu_move_sequencer

Overview:
- Parametrised successor to the two-stage computer-turn sequencer: arms on a computer-turn request, gates on the computer-player enable, then issues a move.
- Adds a configurable think delay, a board-occupancy snapshot with free-cell selection, a valid/ready move handshake, board-full detection and a turn counter.
- Sits between the game-control FSM (which raises start) and the board register file (which consumes move_idx).

Parameters:
- CELLS, 9: number of board cells; board_occ width.
- IDX_W, 4: move_idx width; must satisfy 2**IDX_W >= CELLS.
- THINK_CYCLES, 3: delay cycles spent in THINK; 0 allowed.
- CNT_W, 8: turn_count width.
- CENTER_IDX, 4: preferred cell when CPU_CENTER_FIRST_EN is defined; must be < CELLS.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  computer-turn request, sampled high for one or more cycles.
- cpu_en  input  1  computer player enabled; qualifies start and holds the operation alive.
- board_occ  input  CELLS  1 = cell occupied.
- move_ready  input  1  board accepts the move.
- move_valid  output  1  move offered.
- move_idx  output  IDX_W  chosen cell index.
- busy  output  1  state != IDLE.
- no_move  output  1  one-cycle pulse: board full, no move issued.
- turn_count  output  CNT_W  accepted-move count, wraps modulo 2**CNT_W.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE, move_valid=0, move_idx=0, no_move=0, turn_count=0, think counter=0, snapshot=0. busy=0 follows from state=IDLE.
- States: IDLE, ARM, THINK, OFFER, FULL.
- IDLE:
  - start=1 and cpu_en=1 -> ARM.
  - start with cpu_en=0 is ignored.
- ARM (one cycle):
  - Latch board_occ into the snapshot.
  - Snapshot all ones -> FULL.
  - Else THINK_CYCLES=0 -> OFFER.
  - Else -> THINK with cnt=THINK_CYCLES.
- THINK:
  - cnt decrements each cycle.
  - cnt==1 -> OFFER.
- Move selection: on OFFER entry, move_idx = lowest index i with snapshot[i]==0. move_idx stays stable while in OFFER.
- Latency: start sampled at edge k -> move_valid=1 after edge k+2+THINK_CYCLES.
- OFFER:
  - move_valid=1.
  - move_ready=1 -> IDLE; move_valid=0 next cycle; turn_count+1 (wraps).
- FULL: no_move=1 for exactly one cycle -> IDLE. turn_count is unchanged.
- Abort: cpu_en=0 in ARM/THINK/OFFER -> IDLE next edge, move_valid cleared, no count.
- Simultaneous events in OFFER: move_ready=1 together with cpu_en=0 counts as accepted (handshake wins).
- start while busy=1 is ignored; no queuing.
- board_occ changes after ARM are ignored until the next request.
- Reset asserted mid-operation returns to the reset values immediately, regardless of state.

Optional Feature:
- Macro: CPU_CENTER_FIRST_EN.
- Defined: in selection, if snapshot[CENTER_IDX]==0 then move_idx=CENTER_IDX; otherwise the lowest free index.
- Undefined: lowest free index only.
- Timing and handshake are identical in both builds.

Test Plan (defaults unless stated):
- Latency: board_occ=9'h000, start pulse at edge k, move_ready=1 -> move_valid high after edge k+5, move_idx=0, turn_count 0->1. With CPU_CENTER_FIRST_EN defined: move_idx=4.
- Selection: board_occ=9'h017 (cells 0,1,2,4 occupied) -> move_idx=3 in both builds. board_occ=9'h00F -> move_idx=4 in both builds (lowest free cell is the center).
- Full board: board_occ=9'h1FF, start -> no_move pulses one cycle 2 edges after start; move_valid stays 0; turn_count unchanged.
- Backpressure and abort:
  - move_ready=0 for 4 cycles -> move_valid held with move_idx stable; move_ready=1 -> one acceptance.
  - Repeat with cpu_en dropped in THINK -> IDLE, no move, no count.
- Ignored inputs:
  - start with cpu_en=0 -> busy stays 0.
  - start re-pulsed during THINK -> exactly one move issued.
  - THINK_CYCLES=0 -> move_valid after edge k+2.
- Reset and wrap:
  - Assert reset in OFFER -> move_valid=0 and turn_count=0 without a clock edge.
  - CNT_W=2 with 4 accepted moves -> turn_count wraps 3->0.
